window_shift_buf: RTL and testbench
===================================

# window_shift_buf

Parametrised sliding-window buffer between the feature-line read path and the select/PE array of the convolution engine. It accepts one `TN`-channel column of `KMAX` features per handshake and shifts it into a `KMAX`-column window. It then presents the full `TN x K x K` window with valid/ready flow control. Kernel size `K` and column stride `S` are set at run time, and unused rows and columns are zero-masked.

## Interface
- `TN`, 4, parallel input channels per column
- `KMAX`, 5, maximum kernel size (window rows/columns held)
- `FEATURE_WIDTH`, 16, bits per feature
- `CNT_WIDTH`, 16, width of emitted-window counter
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cfg_load`  in  1  one-cycle pulse; latch config, flush window state
- `cfg_kernel_size`  in  4  K; 0 treated as 1, >KMAX treated as KMAX
- `cfg_stride`  in  4  S, columns between windows; 0 treated as 1
- `in_valid`  in  1  column valid
- `in_ready`  out  1  buffer accepts a column
- `in_data`  in  TN*KMAX*FEATURE_WIDTH  column; lane (c,r) at index (c*KMAX+r)*FEATURE_WIDTH
- `win_valid`  out  1  window presented
- `win_ready`  in  1  consumer takes window
- `win_data`  out  TN*KMAX*KMAX*FEATURE_WIDTH  window; element (c,col,r) at ((c*KMAX+col)*KMAX+r)*FEATURE_WIDTH; col 0 = newest
- `win_cnt`  out  CNT_WIDTH  windows emitted since last cfg_load, wraps

## Operation
- States: IDLE, FILL, WIN.
- IDLE (after reset): `in_ready`=0, `win_valid`=0. Leaves only on `cfg_load`.
- `cfg_load` in any state:
  - latch clamped K, S; `need`=K; `fill_cnt`=0; `win_cnt`=0; clear all window registers to 0; next state FILL.
  - A column or window handshake in the same cycle is ignored; `cfg_load` wins.
- FILL: `in_ready`=1.
  - On `in_valid`: every column slot j shifts to j+1 (slot KMAX-1 discarded); `in_data` enters slot 0; `fill_cnt`++.
  - When the accepted column makes `fill_cnt`==`need`, next state WIN.
- WIN: `in_ready`=0, `win_valid`=1; `win_data` held stable.
  - On `win_ready`: `win_cnt`++, `need`=S, `fill_cnt`=0, next state FILL.
- Masking (combinational on output): rows r>=K and columns col>=K read as 0. Stored registers are unmasked.
- S>K is legal; surplus columns shift through the discarded end.
- K=1, S=1 gives one window per column.

## Timing
- Reset values: `in_ready`=0, `win_valid`=0, `win_data`=0, `win_cnt`=0, state IDLE.
- `cfg_load` at edge n: `in_ready`=1 from cycle n+1.
- The column completing `need` is accepted at edge n. `win_valid`=1 from cycle n+1 and `in_ready`=0 from cycle n+1, both registered.
- Window accepted at edge m: `win_valid`=0 and `in_ready`=1 from cycle m+1.
- Minimum period between windows is S+1 cycles. First window arrives K+1 cycles after `cfg_load`, given back-to-back input.
- `in_ready` and `win_valid` are never high together. They depend only on state, not on `in_valid` or `win_ready`.
- `rst` mid-operation: return to IDLE next cycle, data discarded, `cfg_load` required again.
- `win_cnt` wraps from 2^CNT_WIDTH-1 to 0.

## Structure
- Shared package `tproc_buf_pkg`:
  - state enum (IDLE=0, FILL=1, WIN=2)
  - `clamp_ksize` function (0→1, >KMAX→KMAX)
  - `clamp_stride` function (0→1)
- Sub-module `window_col_shift`: `KMAX`-deep column shift register with shift-enable and synchronous clear. Top level holds the FSM, counters and output masking.

## Test plan
- K=3, S=1, 5 back-to-back columns (column i, all lanes = i+1), `win_ready`=1:
  - first `win_valid` 4 cycles after `cfg_load`; window cols 0..2 = 3,2,1
  - rows 3..4 and cols 3..4 = 0
  - then windows {4,3,2} and {5,4,3}; `win_cnt` ends at 3
- K=3, S=2: 7 columns → windows {3,2,1}, {5,4,3}, {7,6,5}; `in_ready` low while `win_valid` high.
- Backpressure: hold `win_ready`=0 for 10 cycles in WIN → `win_data` unchanged, `in_ready`=0, no column consumed.
- Clamp: K=0 → 1x1 windows, one per column; K=9 with KMAX=5 → behaves as K=5.
- `cfg_load` asserted in WIN with `win_ready`=1 → `win_cnt`=0, `win_valid`=0, FILL next cycle, window zeroed.
- `rst` pulse mid-FILL → IDLE; `in_ready` stays 0 until the next `cfg_load`.

Source files
------------

// File: rtl/tproc_buf_pkg.sv
// Shared types and config helpers for the feature-line window buffer.
package tproc_buf_pkg;

    localparam int unsigned CFG_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        WIN  = 2'd2
    } buf_state_e;

    // Kernel size: 0 means 1, anything above the window depth saturates.
    function automatic logic [CFG_W-1:0] clamp_ksize(input logic [CFG_W-1:0] k,
                                                     input logic [CFG_W-1:0] kmax);
        if (k == '0)
            return CFG_W'(1);
        else if (k > kmax)
            return kmax;
        else
            return k;
    endfunction

    // Stride: 0 means 1.
    function automatic logic [CFG_W-1:0] clamp_stride(input logic [CFG_W-1:0] s);
        return (s == '0) ? CFG_W'(1) : s;
    endfunction

endpackage

// File: rtl/window_col_shift.sv
// KMAX-deep column shift register; slot 0 holds the newest column.
module window_col_shift #(
    parameter int unsigned TN            = 4,
    parameter int unsigned KMAX          = 5,
    parameter int unsigned FEATURE_WIDTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clr,
    input  logic                                  shift_en,
    input  logic [TN*KMAX*FEATURE_WIDTH-1:0]      col_in,
    output logic [TN*KMAX*KMAX*FEATURE_WIDTH-1:0] win_raw
);

    localparam int unsigned COL_W = TN * KMAX * FEATURE_WIDTH;

    logic [COL_W-1:0] slot_q [KMAX];

    // Shift columns toward the old end; clear flushes every slot.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int j = 0; j < int'(KMAX); j++)
                slot_q[j] <= '0;
        end else if (shift_en) begin
            slot_q[0] <= col_in;
            for (int j = 1; j < int'(KMAX); j++)
                slot_q[j] <= slot_q[j-1];
        end
    end

    // Re-pack slot/lane storage into (channel, column, row) window order.
    for (genvar c = 0; c < int'(TN); c++) begin : g_ch
        for (genvar col = 0; col < int'(KMAX); col++) begin : g_col
            for (genvar r = 0; r < int'(KMAX); r++) begin : g_row
                assign win_raw[((c*KMAX+col)*KMAX+r)*FEATURE_WIDTH +: FEATURE_WIDTH] =
                    slot_q[col][(c*KMAX+r)*FEATURE_WIDTH +: FEATURE_WIDTH];
            end
        end
    end

endmodule

// File: rtl/window_shift_buf.sv
// Sliding-window buffer: shifts in feature columns, presents K x K windows with stride S.
module window_shift_buf
    import tproc_buf_pkg::*;
#(
    parameter int unsigned TN            = 4,
    parameter int unsigned KMAX          = 5,
    parameter int unsigned FEATURE_WIDTH = 16,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cfg_load,
    input  logic [3:0]                            cfg_kernel_size,
    input  logic [3:0]                            cfg_stride,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [TN*KMAX*FEATURE_WIDTH-1:0]      in_data,
    output logic                                  win_valid,
    input  logic                                  win_ready,
    output logic [TN*KMAX*KMAX*FEATURE_WIDTH-1:0] win_data,
    output logic [CNT_WIDTH-1:0]                  win_cnt
);

    localparam int unsigned WIN_W  = TN * KMAX * KMAX * FEATURE_WIDTH;
    localparam int unsigned FILL_W = CFG_W + 1;

    buf_state_e        state_q, state_d;
    logic [CFG_W-1:0]  k_q, s_q, need_q;
    logic [FILL_W-1:0] fill_q;
    logic              col_acc, win_acc;
    logic [WIN_W-1:0]  win_raw;

    // Next state and handshake decode; cfg_load overrides any handshake.
    always_comb begin
        state_d = state_q;
        col_acc = 1'b0;
        win_acc = 1'b0;
        if (cfg_load) begin
            state_d = FILL;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                FILL: begin
                    if (in_valid) begin
                        col_acc = 1'b1;
                        if (fill_q + FILL_W'(1) == FILL_W'(need_q))
                            state_d = WIN;
                    end
                end
                WIN: begin
                    if (win_ready) begin
                        win_acc = 1'b1;
                        state_d = FILL;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register with registered handshake flags derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            in_ready  <= 1'b0;
            win_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == FILL);
            win_valid <= (state_d == WIN);
        end
    end

    // Config latch, fill progress and emitted-window counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q     <= CFG_W'(1);
            s_q     <= CFG_W'(1);
            need_q  <= CFG_W'(1);
            fill_q  <= '0;
            win_cnt <= '0;
        end else if (cfg_load) begin
            k_q     <= clamp_ksize(cfg_kernel_size, CFG_W'(KMAX));
            s_q     <= clamp_stride(cfg_stride);
            need_q  <= clamp_ksize(cfg_kernel_size, CFG_W'(KMAX));
            fill_q  <= '0;
            win_cnt <= '0;
        end else if (col_acc) begin
            fill_q  <= fill_q + FILL_W'(1);
        end else if (win_acc) begin
            win_cnt <= win_cnt + CNT_WIDTH'(1);
            need_q  <= s_q;
            fill_q  <= '0;
        end
    end

    window_col_shift #(
        .TN            (TN),
        .KMAX          (KMAX),
        .FEATURE_WIDTH (FEATURE_WIDTH)
    ) u_col_shift (
        .clk      (clk),
        .rst      (rst),
        .clr      (cfg_load),
        .shift_en (col_acc),
        .col_in   (in_data),
        .win_raw  (win_raw)
    );

    // Zero rows and columns beyond the active kernel size on the way out.
    for (genvar c = 0; c < int'(TN); c++) begin : g_ch
        for (genvar col = 0; col < int'(KMAX); col++) begin : g_col
            for (genvar r = 0; r < int'(KMAX); r++) begin : g_row
                localparam int unsigned IDX = ((c*KMAX+col)*KMAX+r)*FEATURE_WIDTH;
                assign win_data[IDX +: FEATURE_WIDTH] =
                    ((CFG_W'(col) < k_q) && (CFG_W'(r) < k_q)) ? win_raw[IDX +: FEATURE_WIDTH]
                                                             : '0;
            end
        end
    end

endmodule

// File: tb/tb_window_shift_buf.sv
// Self-checking bench for window_shift_buf: cycle model plus directed literal checks.
module tb_window_shift_buf;

    localparam int TN    = 4;
    localparam int KMAX  = 5;
    localparam int FW    = 16;
    localparam int CW    = 16;
    localparam int COL_W = TN * KMAX * FW;
    localparam int WIN_W = COL_W * KMAX;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_load;
    logic [3:0]       cfg_kernel_size;
    logic [3:0]       cfg_stride;
    logic             in_valid;
    logic             in_ready;
    logic [COL_W-1:0] in_data;
    logic             win_valid;
    logic             win_ready;
    logic [WIN_W-1:0] win_data;
    logic [CW-1:0]    win_cnt;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    window_shift_buf #(
        .TN(TN), .KMAX(KMAX), .FEATURE_WIDTH(FW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load),
        .cfg_kernel_size(cfg_kernel_size), .cfg_stride(cfg_stride),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .win_valid(win_valid), .win_ready(win_ready),
        .win_data(win_data), .win_cnt(win_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Mode: 0 idle, 1 collecting columns, 2 holding a window.
    int               m_mode = 0;
    int               m_k = 1, m_s = 1, m_need = 1, m_fill = 0;
    logic [CW-1:0]    m_cnt = '0;
    logic [COL_W-1:0] m_hist [KMAX];

    function automatic int clampk(input int k);
        return (k == 0) ? 1 : ((k > KMAX) ? KMAX : k);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0;
            m_cnt  = '0;
            for (int j = 0; j < KMAX; j++) m_hist[j] = '0;
        end else if (cfg_load) begin
            m_k    = clampk(int'(cfg_kernel_size));
            m_s    = (cfg_stride == 4'd0) ? 1 : int'(cfg_stride);
            m_need = m_k;
            m_fill = 0;
            m_cnt  = '0;
            m_mode = 1;
            for (int j = 0; j < KMAX; j++) m_hist[j] = '0;
        end else if (m_mode == 1 && in_valid) begin
            for (int j = KMAX - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = in_data;
            m_fill++;
            if (m_fill == m_need) m_mode = 2;
        end else if (m_mode == 2 && win_ready) begin
            m_cnt  = m_cnt + 1'b1;
            m_need = m_s;
            m_fill = 0;
            m_mode = 1;
        end
    end

    function automatic logic [FW-1:0] model_elem(input int c, input int col, input int r);
        if (col < m_k && r < m_k) return m_hist[col][(c*KMAX+r)*FW +: FW];
        return '0;
    endfunction

    function automatic logic [FW-1:0] dut_elem(input int c, input int col, input int r);
        return win_data[((c*KMAX+col)*KMAX+r)*FW +: FW];
    endfunction

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit bad;
            checks += 5;
            if (in_ready !== (m_mode == 1)) begin
                failures++;
                $display("FAIL in_ready t=%0t got=%b exp=%b", $time, in_ready, m_mode == 1);
            end
            if (win_valid !== (m_mode == 2)) begin
                failures++;
                $display("FAIL win_valid t=%0t got=%b exp=%b", $time, win_valid, m_mode == 2);
            end
            if (in_ready && win_valid) begin
                failures++;
                $display("FAIL ready_valid_excl t=%0t got=both_high exp=exclusive", $time);
            end
            if (win_cnt !== m_cnt) begin
                failures++;
                $display("FAIL win_cnt t=%0t got=%0d exp=%0d", $time, win_cnt, m_cnt);
            end
            bad = 1'b0;
            for (int c = 0; c < TN && !bad; c++)
                for (int col = 0; col < KMAX && !bad; col++)
                    for (int r = 0; r < KMAX && !bad; r++)
                        if (dut_elem(c, col, r) !== model_elem(c, col, r)) begin
                            bad = 1'b1;
                            failures++;
                            $display("FAIL win_data t=%0t c=%0d col=%0d r=%0d got=%h exp=%h",
                                     $time, c, col, r, dut_elem(c, col, r), model_elem(c, col, r));
                        end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Lane (c,r) of column v carries {c, r, v} so lane mapping errors are visible.
    function automatic logic [COL_W-1:0] mk_col(input int v);
        logic [COL_W-1:0] d;
        d = '0;
        for (int c = 0; c < TN; c++)
            for (int r = 0; r < KMAX; r++)
                d[(c*KMAX+r)*FW +: FW] = {4'(c), 4'(r), 8'(v)};
        return d;
    endfunction

    task automatic do_cfg(input int k, input int s);
        cfg_kernel_size = 4'(k);
        cfg_stride      = 4'(s);
        cfg_load        = 1'b1;
        tick();
        cfg_load        = 1'b0;
    endtask

    task automatic send_col(input int v);
        int t;
        in_valid = 1'b1;
        in_data  = mk_col(v);
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_col_timeout got=no_ready exp=ready v=%0d", v);
        end
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_load = 1'b0; cfg_kernel_size = '0; cfg_stride = '0;
        in_valid = 1'b0; in_data = '0; win_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_win_valid", 32'(win_valid), 32'd0);
        check("reset_win_data0", 32'(dut_elem(0, 0, 0)), 32'd0);
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // K=3 S=1, five back-to-back columns.
        win_ready = 1'b1;
        do_cfg(3, 1);
        check("cfg_in_ready", 32'(in_ready), 32'd1);
        for (int v = 1; v <= 3; v++) send_col(v);
        check("t1_first_valid", 32'(win_valid), 32'd1);
        check("t1_e000", 32'(dut_elem(0, 0, 0)), 32'h0003);
        check("t1_e121", 32'(dut_elem(1, 2, 1)), 32'h1101);
        check("t1_row_mask", 32'(dut_elem(2, 1, 3)), 32'h0);
        for (int v = 4; v <= 5; v++) send_col(v);
        check("t1_last_e010", 32'(dut_elem(0, 1, 0)), 32'h0004);
        check("t1_col_mask", 32'(dut_elem(0, 3, 0)), 32'h0);
        tick();
        check("t1_win_cnt", 32'(win_cnt), 32'd3);

        // K=3 S=2, seven columns.
        do_cfg(3, 2);
        for (int v = 1; v <= 7; v++) send_col(v);
        check("t2_e002", 32'(dut_elem(0, 0, 2)), 32'h0207);
        check("t2_e320", 32'(dut_elem(3, 2, 0)), 32'h3005);
        tick();
        check("t2_win_cnt", 32'(win_cnt), 32'd3);

        // Backpressure in WIN.
        win_ready = 1'b0;
        do_cfg(2, 1);
        send_col(1);
        send_col(2);
        in_valid = 1'b1;
        in_data  = mk_col(3);
        repeat (10) tick();
        check("t3_in_ready", 32'(in_ready), 32'd0);
        check("t3_e000", 32'(dut_elem(0, 0, 0)), 32'h0002);
        check("t3_e010", 32'(dut_elem(0, 1, 0)), 32'h0001);
        win_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        check("t3_after_e000", 32'(dut_elem(0, 0, 0)), 32'h0003);

        // Clamp K=0 -> 1x1.
        do_cfg(0, 0);
        for (int v = 1; v <= 3; v++) send_col(v);
        check("t4_k0_row_mask", 32'(dut_elem(0, 0, 1)), 32'h0);
        tick();
        check("t4_k0_win_cnt", 32'(win_cnt), 32'd3);

        // Clamp K=9 -> 5.
        do_cfg(9, 1);
        for (int v = 1; v <= 5; v++) send_col(v);
        check("t4_k9_valid", 32'(win_valid), 32'd1);
        check("t4_k9_e044", 32'(dut_elem(0, 4, 4)), 32'h0401);
        tick();

        // cfg_load in WIN overrides window handshake.
        win_ready = 1'b0;
        do_cfg(2, 1);
        send_col(1);
        send_col(2);
        win_ready = 1'b1;
        do_cfg(2, 1);
        check("t5_win_cnt", 32'(win_cnt), 32'd0);
        check("t5_win_valid", 32'(win_valid), 32'd0);
        check("t5_in_ready", 32'(in_ready), 32'd1);
        check("t5_e000", 32'(dut_elem(0, 0, 0)), 32'h0);

        // Reset mid-FILL.
        do_cfg(3, 1);
        send_col(1);
        in_valid = 1'b1;
        in_data  = mk_col(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_in_ready", 32'(in_ready), 32'd0);
        repeat (3) tick();
        check("t6_in_ready_hold", 32'(in_ready), 32'd0);
        check("t6_e000", 32'(dut_elem(0, 0, 0)), 32'h0);
        in_valid = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
